// File: rtl/tube_blink_scheduler.sv
// ============================================================================
// Module      : tube_blink_scheduler
// Description : CPU-to-digitalTube write forwarder with a hardware digit blink
//               engine that rewrites the special register on each phase change.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tube_blink_scheduler #(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_write_enable,
    input  logic [2:0]  cpu_address,
    input  logic [15:0] cpu_write_data,
    output logic        tube_write_en,
    output logic [2:0]  tube_address,
    output logic [15:0] tube_write_data,
    output logic        blink_phase
);

    localparam logic [2:0] c_addr_low     = 3'b000;
    localparam logic [2:0] c_addr_high    = 3'b010;
    localparam logic [2:0] c_addr_special = 3'b100;
    localparam logic [2:0] c_addr_ctrl    = 3'b110;
    localparam logic [PRESCALE_W-1:0] c_presc_max = PRESCALE_W'(PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                r_state, w_state_n;
    logic                  r_tube_en, w_tube_en_n;
    logic [2:0]            r_tube_addr, w_tube_addr_n;
    logic [15:0]           r_tube_data, w_tube_data_n;
    logic                  r_phase, w_phase_n;
    logic [15:0]           r_shadow, w_shadow_n;
    logic [7:0]            r_mask, w_mask_n;
    logic [7:0]            r_period, w_period_n;
    logic [PRESCALE_W-1:0] r_prescaler, w_prescaler_n;
    logic [7:0]            r_period_cnt, w_period_cnt_n;

    logic w_timer_run;
    logic w_tick;
    logic w_toggle;
    logic w_engine_issue;

    // Upper byte holds the digit-enable bits; blinked digits are cleared in the off phase.
    function automatic logic [15:0] masked_special(
        input logic [15:0] data,
        input logic        phase,
        input logic [7:0]  mask
    );
        masked_special = {data[15:8] & ~(phase ? 8'h00 : mask), data[7:0]};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tube_en    <= 1'b0;
            r_tube_addr  <= 3'b000;
            r_tube_data  <= 16'h0000;
            r_phase      <= 1'b1;
            r_shadow     <= 16'h0000;
            r_mask       <= 8'h00;
            r_period     <= 8'h00;
            r_prescaler  <= '0;
            r_period_cnt <= 8'h00;
        end else begin
            r_state      <= w_state_n;
            r_tube_en    <= w_tube_en_n;
            r_tube_addr  <= w_tube_addr_n;
            r_tube_data  <= w_tube_data_n;
            r_phase      <= w_phase_n;
            r_shadow     <= w_shadow_n;
            r_mask       <= w_mask_n;
            r_period     <= w_period_n;
            r_prescaler  <= w_prescaler_n;
            r_period_cnt <= w_period_cnt_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_tube_en_n    = 1'b0;
        w_tube_addr_n  = r_tube_addr;
        w_tube_data_n  = r_tube_data;
        w_phase_n      = r_phase;
        w_shadow_n     = r_shadow;
        w_mask_n       = r_mask;
        w_period_n     = r_period;
        w_prescaler_n  = r_prescaler;
        w_period_cnt_n = r_period_cnt;

        w_timer_run    = (r_period != 8'h00);
        w_tick         = w_timer_run && (r_prescaler == c_presc_max);
        w_toggle       = w_tick && (r_period_cnt == (r_period - 8'd1));
        w_engine_issue = (r_state == ST_PEND) && !cpu_write_enable;

        if (w_timer_run) begin
            if (w_tick) begin
                w_prescaler_n = '0;
                if (w_toggle) begin
                    w_period_cnt_n = 8'h00;
                    w_phase_n      = ~r_phase;
                end else begin
                    w_period_cnt_n = r_period_cnt + 8'd1;
                end
            end else begin
                w_prescaler_n = r_prescaler + 1'b1;
            end
        end else begin
            w_prescaler_n  = '0;
            w_period_cnt_n = 8'h00;
            w_phase_n      = 1'b1;
        end

        // An issue that coincides with a toggle writes the post-toggle image,
        // so the engine never needs two back-to-back writes.
        if (w_engine_issue) begin
            w_tube_en_n   = 1'b1;
            w_tube_addr_n = c_addr_special;
            w_tube_data_n = masked_special(r_shadow, w_phase_n, r_mask);
            w_state_n     = ST_IDLE;
        end else if (w_toggle) begin
            w_state_n = ST_PEND;
        end

        if (cpu_write_enable) begin
            case (cpu_address)
                c_addr_low, c_addr_high: begin
                    w_tube_en_n   = 1'b1;
                    w_tube_addr_n = cpu_address;
                    w_tube_data_n = cpu_write_data;
                end
                c_addr_special: begin
                    w_shadow_n    = cpu_write_data;
                    w_tube_en_n   = 1'b1;
                    w_tube_addr_n = c_addr_special;
                    w_tube_data_n = masked_special(cpu_write_data, r_phase, r_mask);
                    // Pre-toggle phase was used, so a same-cycle toggle still needs a refresh.
                    if (!w_toggle) begin
                        w_state_n = ST_IDLE;
                    end
                end
                c_addr_ctrl: begin
                    w_mask_n       = cpu_write_data[7:0];
                    w_period_n     = cpu_write_data[15:8];
                    w_prescaler_n  = '0;
                    w_period_cnt_n = 8'h00;
                    w_phase_n      = 1'b1;
                    w_state_n      = ST_PEND;
                end
                default: begin
                end
            endcase
        end
    end

    assign tube_write_en   = r_tube_en;
    assign tube_address    = r_tube_addr;
    assign tube_write_data = r_tube_data;
    assign blink_phase     = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_tube_blink_scheduler.sv
// ============================================================================
// Module      : tb_tube_blink_scheduler
// Description : Directed self-checking bench for tube_blink_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tube_blink_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_write_enable = 1'b0;
    logic [2:0]  cpu_address = 3'b000;
    logic [15:0] cpu_write_data = 16'h0000;
    logic        tube_write_en;
    logic [2:0]  tube_address;
    logic [15:0] tube_write_data;
    logic        blink_phase;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    tube_blink_scheduler #(
        .PRESCALE   (4),
        .PRESCALE_W (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_write_enable (cpu_write_enable),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .tube_write_en    (tube_write_en),
        .tube_address     (tube_address),
        .tube_write_data  (tube_write_data),
        .blink_phase      (blink_phase)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to the falling edge that follows rising edge E<k> after the ctrl write.
    task automatic goto(input int k);
        while (cyc < t0 + k) @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        if (tube_write_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", tube_write_en); end
        checks++;
        if (tube_address !== 3'b000) begin errors++; $display("FAIL rst_addr: got %b want 000", tube_address); end
        checks++;
        if (tube_write_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", tube_write_data); end
        checks++;
        if (blink_phase !== 1'b1) begin errors++; $display("FAIL rst_phase: got %b want 1", blink_phase); end
        checks++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_forward;
        cpu_write_enable = 1'b1; cpu_address = 3'b000; cpu_write_data = 16'h1234;
        @(negedge clock);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b000 || tube_write_data !== 16'h1234) begin
            errors++;
            $display("FAIL fwd_low: got en=%b addr=%b data=%h want en=1 addr=000 data=1234",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        @(negedge clock);
        if (tube_write_en !== 1'b0) begin errors++; $display("FAIL fwd_low_once: got en=%b want 0", tube_write_en); end
        checks++;
        cpu_write_enable = 1'b1; cpu_address = 3'b010; cpu_write_data = 16'h5A5A;
        @(negedge clock);
        cpu_address = 3'b011; cpu_write_data = 16'hFFFF;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b010 || tube_write_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL fwd_high: got en=%b addr=%b data=%h want en=1 addr=010 data=5a5a",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        @(negedge clock);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b0) begin errors++; $display("FAIL unused_addr: got en=%b want 0", tube_write_en); end
        checks++;
        @(negedge clock);
    endtask

    task automatic test_blink;
        logic bad;
        cpu_write_enable = 1'b1; cpu_address = 3'b100; cpu_write_data = 16'hFF00;
        @(negedge clock);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'hFF00) begin
            errors++;
            $display("FAIL special_fwd: got en=%b addr=%b data=%h want en=1 addr=100 data=ff00",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        cpu_write_enable = 1'b1; cpu_address = 3'b110; cpu_write_data = 16'h0201;
        t0 = cyc + 1;
        @(negedge clock);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b0 || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_not_fwd: got en=%b phase=%b want en=0 phase=1", tube_write_en, blink_phase);
        end
        checks++;
        goto(1);
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'hFF00) begin
            errors++;
            $display("FAIL refresh: got en=%b addr=%b data=%h want en=1 addr=100 data=ff00",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        bad = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            goto(k);
            if (tube_write_en !== 1'b0) bad = 1'b1;
        end
        if (bad !== 1'b0) begin errors++; $display("FAIL quiet_on: got stray write want none"); end
        checks++;
        if (blink_phase !== 1'b0) begin errors++; $display("FAIL phase_off: got %b want 0", blink_phase); end
        checks++;
        goto(9);
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'hFE00) begin
            errors++;
            $display("FAIL blink_off: got en=%b addr=%b data=%h want en=1 addr=100 data=fe00",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        bad = 1'b0;
        for (int k = 10; k <= 16; k++) begin
            goto(k);
            if (tube_write_en !== 1'b0) bad = 1'b1;
        end
        if (bad !== 1'b0) begin errors++; $display("FAIL quiet_off: got stray write want none"); end
        checks++;
        goto(17);
        if (tube_write_en !== 1'b1 || tube_write_data !== 16'hFF00 || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL blink_on: got en=%b data=%h phase=%b want en=1 data=ff00 phase=1",
                     tube_write_en, tube_write_data, blink_phase);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        goto(23);
        cpu_write_enable = 1'b1; cpu_address = 3'b000; cpu_write_data = 16'hABCD;
        goto(24);
        cpu_write_data = 16'h5678;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b000 || tube_write_data !== 16'hABCD || blink_phase !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cpu1: got en=%b addr=%b data=%h phase=%b want en=1 addr=000 data=abcd phase=0",
                     tube_write_en, tube_address, tube_write_data, blink_phase);
        end
        checks++;
        goto(25);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b000 || tube_write_data !== 16'h5678) begin
            errors++;
            $display("FAIL b2b_cpu2: got en=%b addr=%b data=%h want en=1 addr=000 data=5678",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        goto(26);
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'hFE00) begin
            errors++;
            $display("FAIL b2b_engine: got en=%b addr=%b data=%h want en=1 addr=100 data=fe00",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        goto(27);
        if (tube_write_en !== 1'b0) begin errors++; $display("FAIL b2b_single: got en=%b want 0", tube_write_en); end
        checks++;
    endtask

    task automatic test_special_off;
        logic bad;
        cpu_write_enable = 1'b1; cpu_address = 3'b100; cpu_write_data = 16'h0F03;
        goto(28);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'h0E03) begin
            errors++;
            $display("FAIL spec_off_fwd: got en=%b addr=%b data=%h want en=1 addr=100 data=0e03",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        bad = 1'b0;
        for (int k = 29; k <= 32; k++) begin
            goto(k);
            if (tube_write_en !== 1'b0) bad = 1'b1;
        end
        if (bad !== 1'b0) begin errors++; $display("FAIL spec_off_quiet: got stray write want none"); end
        checks++;
        goto(33);
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'h0F03 || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL spec_next_on: got en=%b addr=%b data=%h phase=%b want en=1 addr=100 data=0f03 phase=1",
                     tube_write_en, tube_address, tube_write_data, blink_phase);
        end
        checks++;
        goto(41);
        if (tube_write_en !== 1'b1 || tube_write_data !== 16'h0E03 || blink_phase !== 1'b0) begin
            errors++;
            $display("FAIL spec_next_off: got en=%b data=%h phase=%b want en=1 data=0e03 phase=0",
                     tube_write_en, tube_write_data, blink_phase);
        end
        checks++;
    endtask

    task automatic test_disable;
        logic bad;
        goto(42);
        cpu_write_enable = 1'b1; cpu_address = 3'b110; cpu_write_data = 16'h0000;
        goto(43);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b0 || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL dis_ctrl: got en=%b phase=%b want en=0 phase=1", tube_write_en, blink_phase);
        end
        checks++;
        goto(44);
        if (tube_write_en !== 1'b1 || tube_address !== 3'b100 || tube_write_data !== 16'h0F03) begin
            errors++;
            $display("FAIL dis_refresh: got en=%b addr=%b data=%h want en=1 addr=100 data=0f03",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        bad = 1'b0;
        for (int k = 45; k <= 64; k++) begin
            goto(k);
            if (tube_write_en !== 1'b0 || blink_phase !== 1'b1) bad = 1'b1;
        end
        if (bad !== 1'b0) begin errors++; $display("FAIL dis_quiet: got write or phase change want none"); end
        checks++;
    endtask

    task automatic test_reset_mid;
        logic bad;
        cpu_write_enable = 1'b1; cpu_address = 3'b110; cpu_write_data = 16'h0201;
        t0 = cyc + 1;
        @(negedge clock);
        cpu_address = 3'b010; cpu_write_data = 16'hBEEF;
        @(negedge clock);
        cpu_write_enable = 1'b0;
        if (tube_write_en !== 1'b1 || tube_address !== 3'b010 || tube_write_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL mid_setup: got en=%b addr=%b data=%h want en=1 addr=010 data=beef",
                     tube_write_en, tube_address, tube_write_data);
        end
        checks++;
        reset = 1'b1;
        #1;
        if (tube_write_en !== 1'b0 || tube_address !== 3'b000 || tube_write_data !== 16'h0000 || blink_phase !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got en=%b addr=%b data=%h phase=%b want en=0 addr=000 data=0000 phase=1",
                     tube_write_en, tube_address, tube_write_data, blink_phase);
        end
        checks++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (tube_write_en !== 1'b0) bad = 1'b1;
        end
        if (bad !== 1'b0) begin errors++; $display("FAIL mid_lost: got engine write want none"); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_blink();
        test_back_to_back();
        test_special_off();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
